// File: rtl/data_stack.sv
// Hardware data stack with a valid/ready command port, a registered result port with
// backpressure, and sticky overflow/underflow flags.
module data_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err_overflow,
  output logic                       err_underflow,
  input  logic                       clr_err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpPush = 3'd1,
    OpPop  = 3'd2,
    OpDup  = 3'd3,
    OpSwap = 3'd4,
    OpDrop = 3'd5,
    OpOver = 3'd6,
    OpPeek = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_ov_q, err_ov_d;
  logic             err_un_q, err_un_d;

  logic             accept, set_ov, set_un;
  logic             n_zero, n_one, n_full;
  logic [AW-1:0]    top_idx, sec_idx;
  logic [WIDTH-1:0] second;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  assign cmd_ready = !(rd_valid_q && !rd_ready);
  assign accept    = cmd_valid && cmd_ready;

  assign n_zero  = (depth_q == '0);
  assign n_one   = (depth_q == DW'(1));
  assign n_full  = (depth_q == DW'(DEPTH));
  assign top_idx = AW'(depth_q - DW'(1));
  assign sec_idx = AW'(depth_q - DW'(2));
  // tos_q mirrors the top entry, so only the second entry needs an array read
  assign second  = mem_q[sec_idx];

  // Decode the accepted op: bounds checks, next state and array write requests
  always_comb begin
    depth_d    = depth_q;
    tos_d      = tos_q;
    rd_valid_d = rd_valid_q && !rd_ready;
    rd_data_d  = rd_data_q;
    set_ov     = 1'b0;
    set_un     = 1'b0;
    wr0_en     = 1'b0;
    wr0_idx    = AW'(depth_q);
    wr0_data   = cmd_data;
    wr1_en     = 1'b0;
    wr1_idx    = sec_idx;
    wr1_data   = tos_q;
    if (accept) begin
      unique case (op_e'(cmd_op))
        OpNop: ;
        OpPush: begin
          if (n_full) set_ov = 1'b1;
          else begin
            wr0_en  = 1'b1;
            depth_d = depth_q + DW'(1);
            tos_d   = cmd_data;
          end
        end
        OpPop, OpDrop: begin
          if (n_zero) set_un = 1'b1;
          else begin
            depth_d = depth_q - DW'(1);
            tos_d   = n_one ? '0 : second;
            if (op_e'(cmd_op) == OpPop) begin
              rd_valid_d = 1'b1;
              rd_data_d  = tos_q;
            end
          end
        end
        OpDup: begin
          if (n_zero) set_un = 1'b1;
          else if (n_full) set_ov = 1'b1;
          else begin
            wr0_en   = 1'b1;
            wr0_data = tos_q;
            depth_d  = depth_q + DW'(1);
          end
        end
        OpSwap: begin
          if (n_zero || n_one) set_un = 1'b1;
          else begin
            wr0_en   = 1'b1;
            wr0_idx  = top_idx;
            wr0_data = second;
            wr1_en   = 1'b1;
            tos_d    = second;
          end
        end
        OpOver: begin
          if (n_zero || n_one) set_un = 1'b1;
          else if (n_full) set_ov = 1'b1;
          else begin
            wr0_en   = 1'b1;
            wr0_data = second;
            depth_d  = depth_q + DW'(1);
            tos_d    = second;
          end
        end
        OpPeek: begin
          if (n_zero) set_un = 1'b1;
          else begin
            rd_valid_d = 1'b1;
            rd_data_d  = tos_q;
          end
        end
      endcase
    end
    // a new error in the same cycle as clr_err still sets the flag
    err_ov_d = (err_ov_q && !clr_err) || set_ov;
    err_un_d = (err_un_q && !clr_err) || set_un;
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[wr0_idx] <= wr0_data;
    if (wr1_en) mem_q[wr1_idx] <= wr1_data;
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q    <= '0;
      tos_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_ov_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else begin
      depth_q    <= depth_d;
      tos_q      <= tos_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_ov_q   <= err_ov_d;
      err_un_q   <= err_un_d;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign tos           = tos_q;
  assign depth         = depth_q;
  assign empty         = n_zero;
  assign full          = n_full;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;

endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: queue-based stack model, result scoreboard, directed and random ops.
module tb_data_stack;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_ready, rd_valid, empty, full, err_overflow, err_underflow;
  logic [W-1:0]  rd_data, tos;
  logic [DW-1:0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] stk[$];    // model stack, back is top
  logic [W-1:0] exp_q[$];  // expected results in delivery order
  bit m_rdv, m_ov, m_un;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .tos(tos), .depth(depth), .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_state();
    int n = stk.size();
    logic [W-1:0] etos = (n > 0) ? stk[n-1] : '0;
    chk("depth", 32'(depth), n);
    chk("tos", 32'(tos), 32'(etos));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == D));
    chk("err_overflow", 32'(err_overflow), 32'(m_ov));
    chk("err_underflow", 32'(err_underflow), 32'(m_un));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("cmd_ready", 32'(cmd_ready), 32'(!(m_rdv && !rd_ready)));
  endtask

  // Apply what the next rising edge does, from the stack rules alone
  task automatic model_edge(input bit v, input logic [2:0] op, input logic [W-1:0] d,
                            input bit rdy, input bit clr);
    int n = stk.size();
    bit acc = v && !(m_rdv && !rdy);
    bit ov = 0, un = 0, res = 0;
    logic [W-1:0] t;
    if (m_rdv && rdy) m_rdv = 0;
    if (acc) begin
      case (op)
        3'd1: if (n >= D) ov = 1; else stk.push_back(d);
        3'd2: if (n < 1) un = 1; else begin t = stk.pop_back(); exp_q.push_back(t); res = 1; end
        3'd3: if (n < 1) un = 1; else if (n >= D) ov = 1; else stk.push_back(stk[n-1]);
        3'd4: if (n < 2) un = 1;
              else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
        3'd5: if (n < 1) un = 1; else t = stk.pop_back();
        3'd6: if (n < 2) un = 1; else if (n >= D) ov = 1; else stk.push_back(stk[n-2]);
        3'd7: if (n < 1) un = 1; else begin exp_q.push_back(stk[n-1]); res = 1; end
        default: ;
      endcase
    end
    if (res) m_rdv = 1;
    m_ov = (m_ov && !clr) || ov;
    m_un = (m_un && !clr) || un;
  endtask

  // One clock: drive inputs, check state at the falling edge, advance the model
  task automatic step(input bit v, input logic [2:0] op, input logic [W-1:0] d,
                      input bit rdy, input bit clr);
    cmd_valid = v; cmd_op = op; cmd_data = d; rd_ready = rdy; clr_err = clr;
    @(negedge clk);
    check_state();
    model_edge(v, op, d, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst depth", 32'(depth), 0);
    chk("rst tos", 32'(tos), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst err_overflow", 32'(err_overflow), 0);
    chk("rst err_underflow", 32'(err_underflow), 0);
  endtask

  // Scoreboard monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected at %0t: got result %0h, expected none", $time, rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #3;
    check_reset_vals();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LIFO order with back-to-back pops
    step(1, 3'd1, 16'h1111, 1, 0);
    step(1, 3'd1, 16'h2222, 1, 0);
    step(1, 3'd1, 16'h3333, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd2, '0, 1, 0);
    step(0, 3'd0, '0, 1, 0);

    // Overflow on the fifth push, then clear
    for (int i = 0; i < 5; i++) step(1, 3'd1, 16'h00A0 + 16'(i), 1, 0);
    step(0, 3'd0, '0, 1, 0);
    step(0, 3'd0, '0, 1, 1);
    step(0, 3'd0, '0, 1, 0);

    // SWAP / OVER / DUP / DROP on [1, 2]
    for (int i = 0; i < 4; i++) step(1, 3'd5, '0, 1, 0);
    step(1, 3'd1, 16'h0001, 1, 0);
    step(1, 3'd1, 16'h0002, 1, 0);
    step(1, 3'd4, '0, 1, 0);
    step(1, 3'd6, '0, 1, 0);
    step(1, 3'd3, '0, 1, 0);
    step(1, 3'd5, '0, 1, 0);
    step(0, 3'd0, '0, 1, 0);

    // Underflow on an empty stack
    for (int i = 0; i < 3; i++) step(1, 3'd5, '0, 1, 0);
    step(1, 3'd2, '0, 1, 0);
    step(1, 3'd5, '0, 1, 0);
    step(1, 3'd4, '0, 1, 0);
    step(1, 3'd3, '0, 1, 0);
    step(1, 3'd6, '0, 1, 0);
    step(0, 3'd0, '0, 1, 0);
    step(0, 3'd0, '0, 1, 1);

    // Backpressure: held PEEK result, stalled POP, then POP on the consuming edge
    step(1, 3'd1, 16'h0055, 1, 0);
    step(1, 3'd1, 16'h0066, 1, 0);
    step(1, 3'd7, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd2, '0, 0, 0);
    step(1, 3'd2, '0, 1, 0);
    step(1, 3'd1, 16'h0077, 1, 0);
    step(1, 3'd1, 16'h0088, 1, 0);
    step(1, 3'd7, '0, 0, 0);

    // Asynchronous reset between edges with a pending result
    cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals();
    stk.delete();
    exp_q.delete();
    m_rdv = 0; m_ov = 0; m_un = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 3'd1, 16'hBEEF, 1, 0);
    step(0, 3'd0, '0, 1, 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Drain any outstanding result
    step(0, 3'd0, '0, 1, 0);
    step(0, 3'd0, '0, 1, 0);
    chk("results drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Hardware data stack that sits directly downstream of the stack CPU's fetch/execute sequencer.
- Replaces the sequencer's task-based push/pop with a real storage block behind a valid/ready command port.
- Holds up to DEPTH words of WIDTH bits.
- Executes stack-manipulation ops and returns popped/peeked values on a registered result port with backpressure.
- Flags overflow and underflow with sticky error bits.

Parameters:
WIDTH, 16, data word width
DEPTH, 16, number of stack entries (>=2)

Ports:
clk  in  1  clock, all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command presented
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  3  operation code (see Behaviour)
cmd_data  in  WIDTH  operand for PUSH
rd_valid  out  1  rd_data holds a result
rd_ready  in  1  consumer takes result this cycle
rd_data  out  WIDTH  popped/peeked value
tos  out  WIDTH  current top-of-stack, 0 when empty
depth  out  $clog2(DEPTH+1)  current entry count
empty  out  1  depth==0
full  out  1  depth==DEPTH
err_overflow  out  1  sticky overflow flag
err_underflow  out  1  sticky underflow flag
clr_err  in  1  synchronous clear of both error flags

Behaviour:
- Reset (async, rst_n low):
  - depth=0, tos=0, rd_valid=0, rd_data=0, err flags=0, empty=1, full=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards any pending result.
- Handshake:
  - Command accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !(rd_valid && !rd_ready), combinational.
  - A result is consumed on an edge with rd_valid && rd_ready.
  - Accepting a result-producing op in the same cycle the old result is consumed is legal; rd_valid stays 1 with new data.
- Opcodes (n = depth before the op):
  - 0 NOP: no effect.
  - 1 PUSH: requires n<DEPTH. Stores cmd_data at the top; depth+1.
  - 2 POP: requires n>=1. rd_data<=top, rd_valid<=1; depth-1.
  - 3 DUP: requires 1<=n<DEPTH. Pushes a copy of top.
  - 4 SWAP: requires n>=2. Exchanges top and second; depth unchanged.
  - 5 DROP: requires n>=1. depth-1; no result.
  - 6 OVER: requires 2<=n<DEPTH. Pushes a copy of the second entry.
  - 7 PEEK: requires n>=1. rd_data<=top, rd_valid<=1; depth unchanged.
- Latency:
  - Single cycle for every op.
  - depth, tos, empty, full and rd_data reflect an op on the edge that accepts it.
  - Values are visible the following cycle.
  - tos is registered and always equals the top entry (0 if empty).
- Errors:
  - An op that violates its requirement leaves the stack, tos and rd port unchanged.
  - It sets err_overflow if the capacity check failed, otherwise err_underflow.
  - DUP/OVER on an empty stack is underflow (underflow has priority over overflow).
  - Error flags stay set until clr_err or reset.
  - clr_err in the same cycle as a new error: the set wins.
- Width rules:
  - Data is passed unmodified; no arithmetic on data.
  - depth never wraps; the bounds checks above prevent wrap.
- Storage:
  - Register array or inferred RAM indexed by depth-1.
  - SWAP and OVER need the second entry, so the top two entries are read in the same cycle.
- When rd_valid is set and rd_ready is low:
  - rd_data is held stable.
  - No command is accepted.

Test Plan:
- Reset, then PUSH 0x1111, 0x2222, 0x3333 back-to-back, then POP ×3 with rd_ready=1 -> rd_data 0x3333, 0x2222, 0x1111 on consecutive cycles; depth 3→0; empty=1; tos=0.
- DEPTH=4: PUSH 5 words (0xA0..0xA4) -> after 4, full=1; 5th sets err_overflow=1; depth stays 4; tos=0x00A3. clr_err -> err_overflow=0.
- Stack [0x0001, 0x0002 top]: SWAP -> tos=0x0001. OVER -> depth 3, tos=0x0002. DUP -> depth 4, tos=0x0002. DROP -> tos=0x0002, depth 3.
- Empty stack: POP, DROP, SWAP, DUP each -> err_underflow=1, rd_valid stays 0, depth 0, err_overflow=0.
- Backpressure: PEEK with rd_ready=0 -> rd_valid=1, cmd_ready=0 for 3 cycles, POP held on cmd_valid not accepted, rd_data stable. Raise rd_ready -> POP accepted same edge, rd_valid remains 1 with the popped value.
- Assert rst_n low for one cycle asynchronously between edges with depth=3 and rd_valid=1 -> all outputs return to reset values immediately; a following PUSH 0xBEEF gives depth=1, tos=0xBEEF.
